// File: rtl/branch_resolver_if.sv
// branch_resolver_if: EX-stage resolve inputs and predictor-training/redirect outputs
interface branch_resolver_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              valid;
  logic              stall;
  logic              is_branch;
  logic              is_jal;
  logic              is_jalr;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] rs1_val;
  logic [ADDR_W-1:0] rs2_val;
  logic [ADDR_W-1:0] imm;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              br_update;
  logic              br;
  logic [ADDR_W-1:0] br_address;
  logic [ADDR_W-1:0] br_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush;
  logic [CNT_W-1:0]  resolved_cnt;
  logic [CNT_W-1:0]  mispredict_cnt;
  modport master (
    output valid, stall, is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val, imm, pc,
           pred_taken, pred_target,
    input  br_update, br, br_address, br_pc, redirect_valid, redirect_pc, flush,
           resolved_cnt, mispredict_cnt
  );
  modport slave (
    input  valid, stall, is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val, imm, pc,
           pred_taken, pred_target,
    output br_update, br, br_address, br_pc, redirect_valid, redirect_pc, flush,
           resolved_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_resolver.sv
// branch_resolver: resolves EX control flow, trains the predictor, redirects and squashes on mispredict
module branch_resolver #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  branch_resolver_if.slave b
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES + 1) : 1;
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t            state_q;
  logic [FW-1:0]     fcnt_q;
  logic              flush_q, br_update_q, br_q, redirect_valid_q;
  logic [ADDR_W-1:0] br_address_q, br_pc_q, redirect_pc_q;
  logic [CNT_W-1:0]  res_cnt_q, mis_cnt_q, res_cnt_d, mis_cnt_d;
  logic              sel_jalr, sel_jal, sel_br, legal, accept, cond, taken, mispredict;
  logic [ADDR_W-1:0] jalr_sum, target, fall;
  // Decode with jalr > jal > branch priority, evaluate the condition and the resolved target
  always_comb begin
    sel_jalr   = b.is_jalr;
    sel_jal    = ~b.is_jalr & b.is_jal;
    sel_br     = ~b.is_jalr & ~b.is_jal & b.is_branch;
    legal      = sel_jalr | sel_jal | (sel_br & (b.funct3[2:1] != 2'b01));
    accept     = b.valid & ~b.stall & (state_q == IDLE) & legal;
    cond       = (b.funct3[2] ? (b.funct3[1] ? (b.rs1_val < b.rs2_val)
                                             : ($signed(b.rs1_val) < $signed(b.rs2_val)))
                              : (b.rs1_val == b.rs2_val)) ^ b.funct3[0];
    taken      = sel_br ? cond : 1'b1;
    jalr_sum   = b.rs1_val + b.imm;
    target     = sel_jalr ? {jalr_sum[ADDR_W-1:1], 1'b0} : b.pc + b.imm;
    fall       = b.pc + ADDR_W'(4);
    mispredict = (taken != b.pred_taken) | (taken & b.pred_taken & (target != b.pred_target));
    res_cnt_d  = &res_cnt_q ? res_cnt_q : res_cnt_q + CNT_W'(1);
    mis_cnt_d  = &mis_cnt_q ? mis_cnt_q : mis_cnt_q + CNT_W'(1);
  end
  // IDLE/FLUSH controller with registered training, redirect and counter outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      fcnt_q           <= '0;
      flush_q          <= 1'b0;
      br_update_q      <= 1'b0;
      br_q             <= 1'b0;
      br_address_q     <= '0;
      br_pc_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      res_cnt_q        <= '0;
      mis_cnt_q        <= '0;
    end else begin
      br_update_q      <= accept;
      redirect_valid_q <= accept & mispredict;
      if (accept) begin
        br_q         <= taken;
        br_address_q <= target;
        br_pc_q      <= b.pc;
        res_cnt_q    <= res_cnt_d;
      end
      if (accept & mispredict) begin
        redirect_pc_q <= taken ? target : fall;
        mis_cnt_q     <= mis_cnt_d;
        state_q       <= FLUSH;
        flush_q       <= 1'b1;
        fcnt_q        <= FW'(FLUSH_CYCLES);
      end
      if (state_q == FLUSH && !b.stall) begin
        if (fcnt_q == FW'(1)) begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        fcnt_q <= fcnt_q - FW'(1);
      end
    end
  end
  assign b.br_update      = br_update_q;
  assign b.br             = br_q;
  assign b.br_address     = br_address_q;
  assign b.br_pc          = br_pc_q;
  assign b.redirect_valid = redirect_valid_q;
  assign b.redirect_pc    = redirect_pc_q;
  assign b.flush          = flush_q;
  assign b.resolved_cnt   = res_cnt_q;
  assign b.mispredict_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: vector table, corner sequences and random traffic against a reference model
module tb_branch_resolver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  branch_resolver_if #(.ADDR_W(32), .CNT_W(32)) bus ();
  branch_resolver_if #(.ADDR_W(32), .CNT_W(2))  bus2 ();
  assign bus2.valid       = bus.valid;
  assign bus2.stall       = bus.stall;
  assign bus2.is_branch   = bus.is_branch;
  assign bus2.is_jal      = bus.is_jal;
  assign bus2.is_jalr     = bus.is_jalr;
  assign bus2.funct3      = bus.funct3;
  assign bus2.rs1_val     = bus.rs1_val;
  assign bus2.rs2_val     = bus.rs2_val;
  assign bus2.imm         = bus.imm;
  assign bus2.pc          = bus.pc;
  assign bus2.pred_taken  = bus.pred_taken;
  assign bus2.pred_target = bus.pred_target;
  branch_resolver #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .b(bus.slave));
  branch_resolver #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .b(bus2.slave));

  int errors = 0;
  int checks = 0;
  int rem;
  longint m_res, m_mis;
  logic e_upd, e_br, e_rv, e_flush;
  logic [31:0] e_addr, e_pc, e_rpc;

  typedef struct {
    logic br, jal, jalr;
    logic [2:0] f3;
    logic [31:0] rs1, rs2, imm, pc;
    logic pt;
    logic [31:0] ptg;
    logic upd, ebr;
    logic [31:0] eaddr;
    logic erv;
    logic [31:0] erpc;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void ref_eval(input logic br, input logic jal, input logic jalr,
                                   input logic [2:0] f3, input logic [31:0] rs1,
                                   input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [31:0] pc, output logic legal,
                                   output logic tk, output logic [31:0] tg);
    legal = 1'b1;
    tk = 1'b1;
    tg = pc + imm;
    if (jalr) tg = (rs1 + imm) & 32'hFFFF_FFFE;
    else if (!jal && br) begin
      case (f3)
        3'd0: tk = (rs1 == rs2);
        3'd1: tk = (rs1 != rs2);
        3'd4: tk = ($signed(rs1) < $signed(rs2));
        3'd5: tk = ($signed(rs1) >= $signed(rs2));
        3'd6: tk = (rs1 < rs2);
        3'd7: tk = (rs1 >= rs2);
        default: legal = 1'b0;
      endcase
    end else if (!jal) legal = 1'b0;
  endfunction

  function automatic longint sat(input longint x, input longint mx);
    return x > mx ? mx : x;
  endfunction

  task automatic model_reset();
    rem = 0; m_res = 0; m_mis = 0;
    e_upd = 0; e_br = 0; e_rv = 0; e_flush = 0;
    e_addr = 0; e_pc = 0; e_rpc = 0;
  endtask

  task automatic model_edge();
    logic lg, tk;
    logic [31:0] tg;
    e_upd = 0;
    e_rv = 0;
    if (rem > 0) begin
      if (!bus.stall) rem--;
    end else if (bus.valid && !bus.stall) begin
      ref_eval(bus.is_branch, bus.is_jal, bus.is_jalr, bus.funct3, bus.rs1_val, bus.rs2_val,
               bus.imm, bus.pc, lg, tk, tg);
      if (lg) begin
        e_upd = 1; e_br = tk; e_addr = tg; e_pc = bus.pc; m_res++;
        if (tk != bus.pred_taken || (tk && bus.pred_taken && tg != bus.pred_target)) begin
          e_rv = 1; e_rpc = tk ? tg : bus.pc + 32'd4; m_mis++; rem = 2;
        end
      end
    end
    e_flush = rem > 0;
  endtask

  task automatic compare_all();
    chk("br_update", bus.br_update, e_upd);
    chk("br", bus.br, e_br);
    chk("br_address", bus.br_address, e_addr);
    chk("br_pc", bus.br_pc, e_pc);
    chk("redirect_valid", bus.redirect_valid, e_rv);
    chk("redirect_pc", bus.redirect_pc, e_rpc);
    chk("flush", bus.flush, e_flush);
    chk("resolved_cnt", bus.resolved_cnt, m_res);
    chk("mispredict_cnt", bus.mispredict_cnt, m_mis);
    chk("sat_flush", bus2.flush, e_flush);
    chk("sat_resolved_cnt", bus2.resolved_cnt, sat(m_res, 3));
    chk("sat_mispredict_cnt", bus2.mispredict_cnt, sat(m_mis, 3));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    bus.valid = 1; bus.stall = 0;
    bus.is_branch = br; bus.is_jal = jal; bus.is_jalr = jalr; bus.funct3 = f3;
    bus.rs1_val = rs1; bus.rs2_val = rs2; bus.imm = imm; bus.pc = pc;
    bus.pred_taken = pt; bus.pred_target = ptg;
  endtask

  task automatic idle();
    bus.valid = 0; bus.stall = 0; bus.is_branch = 0; bus.is_jal = 0; bus.is_jalr = 0;
  endtask

  initial begin
    int n;
    logic lg, tk;
    logic [31:0] tg;
    vt[0]  = '{1'b1,1'b0,1'b0,3'd0,32'd5,32'd5,32'h20,32'h100,1'b1,32'h120, 1'b1,1'b1,32'h120,1'b0,32'h0};
    vt[1]  = '{1'b1,1'b0,1'b0,3'd4,32'hFFFFFFFF,32'd1,32'h30,32'h40,1'b0,32'h0, 1'b1,1'b1,32'h70,1'b1,32'h70};
    vt[2]  = '{1'b1,1'b0,1'b0,3'd6,32'hFFFFFFFF,32'd1,32'h30,32'h40,1'b1,32'h70, 1'b1,1'b0,32'h70,1'b1,32'h44};
    vt[3]  = '{1'b0,1'b0,1'b1,3'd0,32'h1001,32'h0,32'h10,32'h200,1'b1,32'h1010, 1'b1,1'b1,32'h1010,1'b0,32'h0};
    vt[4]  = '{1'b0,1'b0,1'b1,3'd0,32'h1001,32'h0,32'h10,32'h200,1'b1,32'h1014, 1'b1,1'b1,32'h1010,1'b1,32'h1010};
    vt[5]  = '{1'b1,1'b0,1'b0,3'd1,32'd3,32'd3,32'h8,32'h300,1'b0,32'h0, 1'b1,1'b0,32'h308,1'b0,32'h0};
    vt[6]  = '{1'b1,1'b0,1'b0,3'd5,32'd1,32'hFFFFFFFF,32'hFFFFFFF0,32'h10,1'b1,32'h0, 1'b1,1'b1,32'h0,1'b0,32'h0};
    vt[7]  = '{1'b1,1'b0,1'b0,3'd7,32'd1,32'hFFFFFFFF,32'h8,32'hFFFFFFFC,1'b1,32'h4, 1'b1,1'b0,32'h4,1'b1,32'h0};
    vt[8]  = '{1'b1,1'b1,1'b0,3'd0,32'd1,32'd2,32'h100,32'h500,1'b1,32'h600, 1'b1,1'b1,32'h600,1'b0,32'h0};
    vt[9]  = '{1'b0,1'b1,1'b1,3'd0,32'h2000,32'h0,32'h4,32'h700,1'b0,32'h0, 1'b1,1'b1,32'h2004,1'b1,32'h2004};
    vt[10] = '{1'b1,1'b0,1'b0,3'd2,32'd5,32'd5,32'h20,32'h100,1'b1,32'h120, 1'b0,1'b0,32'h0,1'b0,32'h0};
    vt[11] = '{1'b1,1'b0,1'b0,3'd3,32'd5,32'd6,32'h20,32'h900,1'b0,32'h0, 1'b0,1'b0,32'h0,1'b0,32'h0};
    idle();
    bus.funct3 = 0; bus.rs1_val = 0; bus.rs2_val = 0; bus.imm = 0; bus.pc = 0;
    bus.pred_taken = 0; bus.pred_target = 0;
    model_reset();
    cycle();
    cycle();
    #3 rst_n = 1;
    cycle();
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].br, vt[i].jal, vt[i].jalr, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].imm,
            vt[i].pc, vt[i].pt, vt[i].ptg);
      cycle();
      chk($sformatf("vec%0d_update", i), bus.br_update, vt[i].upd);
      if (vt[i].upd) begin
        chk($sformatf("vec%0d_br", i), bus.br, vt[i].ebr);
        chk($sformatf("vec%0d_addr", i), bus.br_address, vt[i].eaddr);
        chk($sformatf("vec%0d_pc", i), bus.br_pc, vt[i].pc);
        chk($sformatf("vec%0d_redirect", i), bus.redirect_valid, vt[i].erv);
        if (vt[i].erv) chk($sformatf("vec%0d_rpc", i), bus.redirect_pc, vt[i].erpc);
      end
      idle();
      repeat (3) cycle();
    end
    drive(1'b1, 1'b0, 1'b0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h30, 32'h40, 1'b0, 32'h0);
    cycle();
    chk("flushseq_redirect", bus.redirect_valid, 1'b1);
    chk("flushseq_flush1", bus.flush, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h40, 32'h80, 1'b1, 32'hC0);
    cycle();
    chk("flushseq_jal_ignored", bus.br_update, 1'b0);
    chk("flushseq_flush2", bus.flush, 1'b1);
    cycle();
    chk("flushseq_jal_ignored2", bus.br_update, 1'b0);
    chk("flushseq_flush_end", bus.flush, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1, 32'h120);
    cycle();
    chk("b2b_first", bus.br_update, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 32'h10, 32'h800, 1'b1, 32'h810);
    cycle();
    chk("b2b_second", bus.br_update, 1'b1);
    chk("b2b_pc", bus.br_pc, 32'h800);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2, 32'h20, 32'h100, 1'b1, 32'h120);
    n = 0;
    cycle();
    if (bus.flush) n++;
    bus.stall = 1;
    repeat (3) begin
      cycle();
      if (bus.flush) n++;
    end
    bus.stall = 0;
    idle();
    repeat (4) begin
      cycle();
      if (bus.flush) n++;
    end
    chk("stalled_flush_len", n, 5);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 32'd1, 32'h20, 32'h100, 1'b1, 32'h120);
    cycle();
    chk("rst_pre_flush", bus.flush, 1'b1);
    idle();
    #2 rst_n = 0;
    #1;
    chk("async_rst_flush", bus.flush, 1'b0);
    chk("async_rst_update", bus.br_update, 1'b0);
    chk("async_rst_res", bus.resolved_cnt, 32'd0);
    chk("async_rst_mis", bus.mispredict_cnt, 32'd0);
    model_reset();
    cycle();
    #3 rst_n = 1;
    cycle();
    for (int i = 0; i < 400; i++) begin
      bus.valid = ($urandom % 4) != 0;
      bus.stall = ($urandom % 5) == 0;
      bus.is_branch = $urandom % 2;
      bus.is_jal = ($urandom % 4) == 0;
      bus.is_jalr = ($urandom % 4) == 0;
      bus.funct3 = 3'($urandom);
      bus.rs1_val = ($urandom % 2) ? $urandom : $urandom % 4;
      bus.rs2_val = ($urandom % 2) ? $urandom : $urandom % 4;
      bus.imm = $urandom;
      bus.pc = $urandom & 32'hFFFF_FFFC;
      ref_eval(bus.is_branch, bus.is_jal, bus.is_jalr, bus.funct3, bus.rs1_val, bus.rs2_val,
               bus.imm, bus.pc, lg, tk, tg);
      bus.pred_taken = ($urandom % 3 == 0) ? ~tk : tk;
      bus.pred_target = ($urandom % 3 == 0) ? $urandom : tg;
      cycle();
    end
    idle();
    repeat (3) cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
